multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 The block SHALL have these inputs:
- op input 7: instr[6:0] of the latched instruction.
- zero input 1: ALU zero flag.
- mem_ready input 1: memory access completes this cycle.
REQ-003 The block SHALL have these single-bit outputs:
- irwrite output 1: instruction-register load.
- pcwrite output 1: PC load.
- regwrite output 1: register-file write.
- memwrite output 1: data-memory write.
- adrsrc output 1: memory address select, 0=PC, 1=Result.
- illegal_op output 1: unsupported opcode seen in DECODE.
REQ-004 The block SHALL have these multi-bit outputs:
- immsrc output 2: immediate-extender select, 00 I, 01 S, 10 B, 11 J.
- alusrca output 2: 00 PC, 01 OldPC, 10 RD1.
- alusrcb output 2: 00 RD2, 01 ImmExt, 10 constant 4.
- resultsrc output 2: 00 ALUOut, 01 Data, 10 ALUResult.
- aluop output 2: 00 add, 01 subtract/compare, 10 funct-decoded.
- state output 4: current FSM state code.
- instret output 32: retired-instruction count.

Function
REQ-005 The FSM states and codes SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next clock.
REQ-006 immsrc SHALL be decoded combinationally from op in every state: 0000011 (lw) or 0010011 (I-ALU) -> 00; 0100011 (sw) -> 01; 1100011 (beq) -> 10; 1101111 (jal) -> 11; any other op -> 00.
REQ-007 Outputs SHALL be Moore functions of state, except pcwrite and illegal_op; every output not listed for a state SHALL be 0.
REQ-008 FETCH SHALL drive adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, and irwrite=pcupdate=mem_ready; FETCH->DECODE only when mem_ready=1, otherwise hold.
REQ-009 DECODE SHALL drive alusrca=01, alusrcb=01, aluop=00, and transition by op: lw/sw->MEMADR, R-type 0110011->EXECUTER, I-ALU->EXECUTEI, beq->BEQ, jal->JAL, other->FETCH with illegal_op=1 for that cycle only.
REQ-010 MEMADR SHALL drive alusrca=10, alusrcb=01, aluop=00, and go to MEMREAD if op=lw, else MEMWRITE.
REQ-011 MEMREAD SHALL drive resultsrc=00, adrsrc=1, and go to MEMWB when mem_ready=1, otherwise hold.
REQ-012 MEMWB SHALL drive resultsrc=01, regwrite=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive resultsrc=00, adrsrc=1, memwrite=1 (held every cycle until mem_ready=1), then go to FETCH on mem_ready=1.
REQ-014 EXECUTER SHALL drive alusrca=10, alusrcb=00, aluop=10; EXECUTEI SHALL drive alusrca=10, alusrcb=01, aluop=10; both SHALL go to ALUWB.
REQ-015 ALUWB SHALL drive resultsrc=00, regwrite=1, then go to FETCH.
REQ-016 BEQ SHALL drive alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, then go to FETCH.
REQ-017 JAL SHALL drive alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1, then go to ALUWB.
REQ-018 pcwrite SHALL equal pcupdate OR (branch AND zero), combinationally.
REQ-019 instret SHALL increment by 1 (mod 2^32, wrapping FFFFFFFF->00000000) on the clock edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE with mem_ready=1; it SHALL NOT increment on an illegal-op return or on any other transition.
REQ-020 Latency, with mem_ready held 1: R/I-ALU 4 cycles, lw 5, sw 4, beq 3, jal 4; each cycle with mem_ready=0 in FETCH, MEMREAD, or MEMWRITE adds one cycle.

Reset
REQ-021 reset=1 at a clock edge SHALL set state=FETCH and instret=0, overriding any transition or increment on that edge.
REQ-022 While reset=1, irwrite, pcwrite, regwrite, memwrite, and illegal_op SHALL be forced to 0 regardless of state; other outputs SHALL follow the current state.
REQ-023 Reset asserted mid-instruction SHALL abandon that instruction without retiring it.

Verification
REQ-024 Reset, mem_ready=1, op=0110011 -> states 0,1,6,8,0; regwrite=1 only in the ALUWB cycle; instret 0->1 after ALUWB.
REQ-025 op=0000011, mem_ready=0 for the first 2 MEMREAD cycles -> states 0,1,2,3,3,3,4,0; adrsrc=1 in all MEMREAD cycles; immsrc=00; instret +1.
REQ-026 op=1100011: zero=1 in BEQ -> pcwrite=1, immsrc=10, aluop=01; repeat with zero=0 -> pcwrite=0; each retires in 3 cycles.
REQ-027 op=0100011, mem_ready=0 for 3 MEMWRITE cycles -> memwrite=1 for 4 consecutive cycles, immsrc=01, then FETCH; instret +1.
REQ-028 op=0000000 -> illegal_op=1 for exactly one cycle (DECODE), next state FETCH, instret unchanged; op=1101111 -> states 0,1,10,8,0, immsrc=11, pcwrite=1 in JAL.
REQ-029 Reset pulsed during MEMWRITE with mem_ready=0 -> memwrite=0 in the reset cycle, state=FETCH and instret=0 on the next cycle; instret preloaded by 2^32 retirements wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style main controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, plus a retired-instruction counter.
//
// state    | code | meaning
// FETCH    | 0    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | 1    | compute branch/jump target, dispatch on opcode
// MEMADR   | 2    | compute load/store address
// MEMREAD  | 3    | load data from memory, wait for mem_ready
// MEMWB    | 4    | write loaded data to the register file
// MEMWRITE | 5    | store to memory, wait for mem_ready
// EXECUTER | 6    | register-register ALU operation
// EXECUTEI | 7    | register-immediate ALU operation
// ALUWB    | 8    | write ALU result to the register file
// BEQ      | 9    | compare operands, branch on zero
// JAL      | 10   | PC <= target, link address toward ALUWB
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        memwrite,
    output logic        adrsrc,
    output logic        illegal_op,
    output logic [1:0]  immsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  resultsrc,
    output logic [1:0]  aluop,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic irwrite_s, regwrite_s, memwrite_s, illegal_s;
    logic pcupdate, branch, retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        irwrite_s  = 1'b0;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        adrsrc     = 1'b0;
        illegal_s  = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        aluop      = 2'b00;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite_s = mem_ready;
                pcupdate  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_s = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + 32'd1 : instret_q;
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Write enables are suppressed during reset; datapath selects still follow state.
    assign irwrite    = irwrite_s & ~reset;
    assign pcwrite    = (pcupdate | (branch & zero)) & ~reset;
    assign regwrite   = regwrite_s & ~reset;
    assign memwrite   = memwrite_s & ~reset;
    assign illegal_op = illegal_s & ~reset;
    assign state      = state_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand-written reset and
// counter-wrap sequences.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [6:0]  op;
    logic        irwrite, pcwrite, regwrite, memwrite, adrsrc, illegal_op;
    logic [1:0]  immsrc, alusrca, alusrcb, resultsrc, aluop;
    logic [3:0]  state;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite),
        .memwrite(memwrite), .adrsrc(adrsrc), .illegal_op(illegal_op),
        .immsrc(immsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .resultsrc(resultsrc), .aluop(aluop), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b0000000;

    // ctl = {irwrite,pcwrite,regwrite,memwrite,adrsrc,illegal_op,
    //        immsrc,alusrca,alusrcb,resultsrc,aluop}
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] ir;
    } vec_t;

    vec_t vt[38];

    function automatic logic [15:0] ctl_now();
        return {irwrite, pcwrite, regwrite, memwrite, adrsrc, illegal_op,
                immsrc, alusrca, alusrcb, resultsrc, aluop};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] o, input logic z, input logic mr);
        @(negedge clk);
        reset = r; op = o; zero = z; mem_ready = mr;
        #1;
    endtask

    initial begin
        vt[0]  = '{1, RT, 0, 1, 4'd0,  16'b000000_00_00_10_10_00, 0};
        vt[1]  = '{0, RT, 0, 1, 4'd0,  16'b110000_00_00_10_10_00, 0};
        vt[2]  = '{0, RT, 1, 1, 4'd1,  16'b000000_00_01_01_00_00, 0};
        vt[3]  = '{0, RT, 1, 1, 4'd6,  16'b000000_00_10_00_00_10, 0};
        vt[4]  = '{0, RT, 1, 1, 4'd8,  16'b001000_00_00_00_00_00, 0};
        vt[5]  = '{0, LW, 0, 1, 4'd0,  16'b110000_00_00_10_10_00, 1};
        vt[6]  = '{0, LW, 0, 1, 4'd1,  16'b000000_00_01_01_00_00, 1};
        vt[7]  = '{0, LW, 0, 1, 4'd2,  16'b000000_00_10_01_00_00, 1};
        vt[8]  = '{0, LW, 1, 0, 4'd3,  16'b000010_00_00_00_00_00, 1};
        vt[9]  = '{0, LW, 1, 0, 4'd3,  16'b000010_00_00_00_00_00, 1};
        vt[10] = '{0, LW, 1, 1, 4'd3,  16'b000010_00_00_00_00_00, 1};
        vt[11] = '{0, LW, 1, 1, 4'd4,  16'b001000_00_00_00_01_00, 1};
        vt[12] = '{0, BQ, 0, 1, 4'd0,  16'b110000_10_00_10_10_00, 2};
        vt[13] = '{0, BQ, 0, 1, 4'd1,  16'b000000_10_01_01_00_00, 2};
        vt[14] = '{0, BQ, 1, 1, 4'd9,  16'b010000_10_10_00_00_01, 2};
        vt[15] = '{0, BQ, 0, 1, 4'd0,  16'b110000_10_00_10_10_00, 3};
        vt[16] = '{0, BQ, 1, 1, 4'd1,  16'b000000_10_01_01_00_00, 3};
        vt[17] = '{0, BQ, 0, 1, 4'd9,  16'b000000_10_10_00_00_01, 3};
        vt[18] = '{0, SW, 0, 1, 4'd0,  16'b110000_01_00_10_10_00, 4};
        vt[19] = '{0, SW, 0, 1, 4'd1,  16'b000000_01_01_01_00_00, 4};
        vt[20] = '{0, SW, 0, 1, 4'd2,  16'b000000_01_10_01_00_00, 4};
        vt[21] = '{0, SW, 1, 0, 4'd5,  16'b000110_01_00_00_00_00, 4};
        vt[22] = '{0, SW, 1, 0, 4'd5,  16'b000110_01_00_00_00_00, 4};
        vt[23] = '{0, SW, 0, 0, 4'd5,  16'b000110_01_00_00_00_00, 4};
        vt[24] = '{0, SW, 0, 1, 4'd5,  16'b000110_01_00_00_00_00, 4};
        vt[25] = '{0, BAD, 0, 0, 4'd0, 16'b000000_00_00_10_10_00, 5};
        vt[26] = '{0, BAD, 0, 1, 4'd0, 16'b110000_00_00_10_10_00, 5};
        vt[27] = '{0, BAD, 1, 1, 4'd1, 16'b000001_00_01_01_00_00, 5};
        vt[28] = '{0, JL, 0, 1, 4'd0,  16'b110000_11_00_10_10_00, 5};
        vt[29] = '{0, JL, 0, 1, 4'd1,  16'b000000_11_01_01_00_00, 5};
        vt[30] = '{0, JL, 0, 1, 4'd10, 16'b010000_11_01_10_00_00, 5};
        vt[31] = '{0, JL, 1, 1, 4'd8,  16'b001000_11_00_00_00_00, 5};
        vt[32] = '{0, IA, 1, 0, 4'd0,  16'b000000_00_00_10_10_00, 6};
        vt[33] = '{0, IA, 0, 1, 4'd0,  16'b110000_00_00_10_10_00, 6};
        vt[34] = '{0, IA, 0, 1, 4'd1,  16'b000000_00_01_01_00_00, 6};
        vt[35] = '{0, IA, 1, 1, 4'd7,  16'b000000_00_10_01_00_10, 6};
        vt[36] = '{0, IA, 0, 1, 4'd8,  16'b001000_00_00_00_00_00, 6};
        vt[37] = '{0, IA, 0, 0, 4'd0,  16'b000000_00_00_10_10_00, 7};

        reset = 1'b1; op = RT; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 38; i++) begin
            drive(vt[i].rst, vt[i].op, vt[i].z, vt[i].mr);
            chk($sformatf("row%0d state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("row%0d ctl", i), 32'(ctl_now()), 32'(vt[i].ctl));
            chk($sformatf("row%0d instret", i), instret, vt[i].ir);
        end

        // Reset pulsed while a store is stalled in MEMWRITE.
        drive(0, SW, 0, 1);
        chk("rst_sw fetch", 32'(state), 32'd0);
        drive(0, SW, 0, 1);
        drive(0, SW, 0, 0);
        drive(0, SW, 0, 0);
        chk("rst_sw memwrite state", 32'(state), 32'd5);
        chk("rst_sw memwrite pre", 32'(memwrite), 32'd1);
        drive(1, SW, 1, 0);
        chk("rst_sw memwrite gated", 32'(memwrite), 32'd0);
        chk("rst_sw adrsrc follows", 32'(adrsrc), 32'd1);
        chk("rst_sw state held", 32'(state), 32'd5);
        drive(0, SW, 0, 0);
        chk("rst_sw state after", 32'(state), 32'd0);
        chk("rst_sw instret after", instret, 32'd0);

        // Counter wrap: preload the counter at its maximum, then retire a beq.
        @(negedge clk);
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        chk("wrap preload", instret, 32'hFFFF_FFFF);
        drive(0, BQ, 0, 1);
        chk("wrap fetch", 32'(state), 32'd0);
        drive(0, BQ, 0, 1);
        drive(0, BQ, 0, 1);
        chk("wrap beq state", 32'(state), 32'd9);
        drive(0, BQ, 0, 0);
        chk("wrap state", 32'(state), 32'd0);
        chk("wrap instret", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
